// File: rtl/sys86_cpu_pkg.sv
// Shared constants and helpers for the System86 CPU support controller.
// Default bus-decode addresses, watchdog state encoding and E/Q phase thresholds.
package sys86_cpu_pkg;

  localparam logic [15:0] WDOG_ADDR_DEF = 16'h8000;
  localparam logic [15:0] IACK_ADDR_DEF = 16'h8400;
  localparam logic [15:0] BANK_ADDR_DEF = 16'h8800;

  typedef enum logic {
    WD_RUN   = 1'b0,
    WD_PULSE = 1'b1
  } wd_state_e;

  typedef struct packed {
    int unsigned q_rise;
    int unsigned q_fall;
    int unsigned e_rise;
  } eq_thr_t;

  // Q is high over the middle half of the E period, E over the second half.
  function automatic eq_thr_t eq_thresholds(input int unsigned clk_div);
    eq_thr_t th;
    th.q_rise = clk_div / 4;
    th.q_fall = (3 * clk_div) / 4;
    th.e_rise = clk_div / 2;
    return th;
  endfunction

endpackage

// File: rtl/sys86_eq_gen.sv
// Quadrature E/Q clock generator: free-running phase counter with registered
// E and Q outputs, plus a strobe marking the last clock of each E period.
module sys86_eq_gen
  import sys86_cpu_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic e_o,
  output logic q_o,
  output logic ph_last_o
);

  localparam int unsigned PH_W = $clog2(CLK_DIV);
  localparam eq_thr_t TH = eq_thresholds(CLK_DIV);
  localparam logic [PH_W-1:0] Q_RISE = PH_W'(TH.q_rise);
  localparam logic [PH_W-1:0] Q_FALL = PH_W'(TH.q_fall);
  localparam logic [PH_W-1:0] E_RISE = PH_W'(TH.e_rise);
  localparam logic [PH_W-1:0] PH_MAX = PH_W'(CLK_DIV - 1);

  logic [PH_W-1:0] ph_q;
  logic [PH_W-1:0] ph_d;
  logic            e_q;
  logic            q_q;

  assign ph_last_o = (ph_q == PH_MAX);
  assign ph_d      = ph_last_o ? '0 : ph_q + 1'b1;

  // E and Q are decoded from the next phase so they line up with ph_q itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q <= '0;
      e_q  <= 1'b0;
      q_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      ph_q <= ph_d;
      e_q  <= (ph_d >= E_RISE);
      q_q  <= (ph_d >= Q_RISE) && (ph_d < Q_FALL);
    end
  end

  assign e_o = e_q;
  assign q_o = q_q;

endmodule

// File: rtl/sys86_cpu_ctrl.sv
// System86 CPU support controller: E/Q clocks, committed-write decode,
// VBLANK interrupt, bank latch and a fully synchronous watchdog reset pulse.
module sys86_cpu_ctrl
  import sys86_cpu_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned WDOG_WIDTH = 4,
  parameter int unsigned WDOG_LIMIT = 10,
  parameter int unsigned RES_PULSE  = 16,
  parameter logic [15:0] WDOG_ADDR  = WDOG_ADDR_DEF,
  parameter logic [15:0] IACK_ADDR  = IACK_ADDR_DEF,
  parameter logic [15:0] BANK_ADDR  = BANK_ADDR_DEF,
  parameter int unsigned BANK_WIDTH = 2
) (
  input  logic                  CLK_6M,
  input  logic                  rst_n,
  input  logic                  nVBLK,
  input  logic                  RnW,
  input  logic [15:0]           A,
  input  logic [7:0]            D,
  output logic                  E,
  output logic                  Q,
  output logic                  nRES,
  output logic                  nIRQ,
  output logic [BANK_WIDTH-1:0] BANK,
  output logic [WDOG_WIDTH-1:0] wdog_count
);

  localparam int unsigned PW = $clog2(RES_PULSE + 1);

  logic                  ph_last;
  logic                  vb_s1_q, vb_s2_q, vb_prev_q;
  wd_state_e             state_q;
  logic [PW-1:0]         pulse_q;
  logic [WDOG_WIDTH-1:0] wdog_q;
  logic                  nirq_q;
  logic [BANK_WIDTH-1:0] bank_q;
  logic                  res_active;
  logic                  commit, kick, iack, bank_wr, vb_start, expire;
  logic                  unused_bits;

  sys86_eq_gen #(.CLK_DIV(CLK_DIV)) u_eq_gen (
    .clk       (CLK_6M),
    .rst_n     (rst_n),
    .e_o       (E),
    .q_o       (Q),
    .ph_last_o (ph_last)
  );

  // Synchroniser and edge detector idle high so release never fakes a VBLANK.
  always_ff @(posedge CLK_6M or negedge rst_n) begin
    if (!rst_n) begin
      vb_s1_q   <= 1'b1;
      vb_s2_q   <= 1'b1;
      vb_prev_q <= 1'b1;
    end else begin
      vb_s1_q   <= nVBLK;
      vb_s2_q   <= vb_s1_q;
      vb_prev_q <= vb_s2_q;
    end
  end

  assign res_active = (state_q == WD_PULSE);
  assign vb_start   = vb_prev_q & ~vb_s2_q;
  assign commit     = ph_last & ~RnW & ~res_active;
  assign kick       = commit & (A[15:10] == WDOG_ADDR[15:10]);
  assign iack       = commit & (A[15:10] == IACK_ADDR[15:10]);
  assign bank_wr    = commit & (A[15:11] == BANK_ADDR[15:11]);
  assign expire     = ~res_active & vb_start & ~kick
                    & (wdog_q == WDOG_WIDTH'(WDOG_LIMIT - 1));

  // A kick beats a coincident VBLANK; a VBLANK beats a coincident acknowledge.
  always_ff @(posedge CLK_6M or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WD_RUN;
      pulse_q <= '0;
      wdog_q  <= '0;
      nirq_q  <= 1'b1;
      bank_q  <= '0;
    end else begin
      unique case (state_q)
        WD_PULSE: begin
          nirq_q  <= 1'b1;
          bank_q  <= '0;
          pulse_q <= pulse_q - 1'b1;
          if (pulse_q == '0) state_q <= WD_RUN;
        end
        WD_RUN: begin
          if (expire) begin
            state_q <= WD_PULSE;
            pulse_q <= PW'(RES_PULSE - 1);
            wdog_q  <= '0;
            nirq_q  <= 1'b1;
            bank_q  <= '0;
          end else begin
            if (kick)          wdog_q <= '0;
            else if (vb_start) wdog_q <= wdog_q + 1'b1;
            if (vb_start)      nirq_q <= 1'b0;
            else if (iack)     nirq_q <= 1'b1;
            if (bank_wr)       bank_q <= D[BANK_WIDTH-1:0];
          end
        end
      endcase
    end
  end

  // rst_n gates nRES directly so the CPU sees reset without waiting for a clock.
  assign nRES       = rst_n & ~res_active;
  assign nIRQ       = nirq_q;
  assign BANK       = bank_q;
  assign wdog_count = wdog_q;

  assign unused_bits = ^{A, D};

endmodule

// File: tb/tb_sys86_cpu_ctrl.sv
// Scoreboard bench for sys86_cpu_ctrl: a frame-level reference model pushes the
// expected outputs for every clock edge; a monitor pops and compares them.
module tb_sys86_cpu_ctrl;

  localparam int DIV   = 4;
  localparam int LIMIT = 10;
  localparam int PULSE = 16;

  typedef struct packed {
    logic       e;
    logic       q;
    logic       e8;
    logic       q8;
    logic       nres;
    logic       nirq;
    logic [1:0] bank;
    logic [3:0] wcnt;
  } snap_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        nvblk = 1'b1;
  logic        rnw   = 1'b1;
  logic [15:0] addr  = '0;
  logic [7:0]  data  = '0;

  logic       e, q, nres, nirq;
  logic [1:0] bank;
  logic [3:0] wcnt;
  logic       e8, q8;
  logic       unused_nres8, unused_nirq8;
  logic [1:0] unused_bank8;
  logic [3:0] unused_wcnt8;

  always #5 clk = ~clk;

  sys86_cpu_ctrl dut (
    .CLK_6M(clk), .rst_n(rst_n), .nVBLK(nvblk), .RnW(rnw), .A(addr), .D(data),
    .E(e), .Q(q), .nRES(nres), .nIRQ(nirq), .BANK(bank), .wdog_count(wcnt)
  );

  sys86_cpu_ctrl #(.CLK_DIV(8)) dut8 (
    .CLK_6M(clk), .rst_n(rst_n), .nVBLK(nvblk), .RnW(rnw), .A(addr), .D(data),
    .E(e8), .Q(q8), .nRES(unused_nres8), .nIRQ(unused_nirq8), .BANK(unused_bank8),
    .wdog_count(unused_wcnt8)
  );

  int    n_cmp = 0;
  int    n_bad = 0;
  snap_t exp_q[$];

  // Reference model state, in terms of edges since reset release.
  int       m_t;
  int       m_cnt;
  int       m_pulse;
  logic     m_nirq;
  logic [1:0] m_bank;
  bit       m_vh[$];
  int       low_cnt = 0;

  task automatic check(input string name, input snap_t act, input snap_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t edge=%0d actual E%b Q%b E8%b Q8%b nRES%b nIRQ%b BANK%0d wdog%0d required E%b Q%b E8%b Q8%b nRES%b nIRQ%b BANK%0d wdog%0d",
               name, $time, m_t, act.e, act.q, act.e8, act.q8, act.nres, act.nirq, act.bank,
               act.wcnt, exp.e, exp.q, exp.e8, exp.q8, exp.nres, exp.nirq, exp.bank, exp.wcnt);
    end
  endtask

  function automatic bit samp(input int j);
    if (j < 1) return 1'b1;
    return m_vh[j-1];
  endfunction

  task automatic model_init();
    m_t = 0; m_cnt = 0; m_pulse = 0; m_nirq = 1'b1; m_bank = 2'b00;
    m_vh.delete();
  endtask

  // One edge of the spec's behaviour, applied to the inputs now on the pins.
  task automatic model_step();
    bit vb, p, cm, kick, iack, bw, expire;
    int ph, ph8;
    snap_t s;
    m_t++;
    m_vh.push_back(nvblk);
    vb     = samp(m_t - 3) && !samp(m_t - 2);
    p      = (m_pulse > 0);
    cm     = (m_t % DIV == 0) && !rnw && !p;
    kick   = cm && (addr[15:10] == 6'h20);
    iack   = cm && (addr[15:10] == 6'h21);
    bw     = cm && (addr[15:11] == 5'h11);
    expire = !p && vb && !kick && (m_cnt == LIMIT - 1);
    if (p) m_pulse--;
    else if (expire) m_pulse = PULSE;
    if (!p) begin
      if (kick || expire) m_cnt = 0;
      else if (vb) m_cnt++;
    end
    if (p || expire) begin
      m_nirq = 1'b1;
      m_bank = 2'b00;
    end else begin
      if (vb) m_nirq = 1'b0;
      else if (iack) m_nirq = 1'b1;
      if (bw) m_bank = data[1:0];
    end
    ph  = m_t % DIV;
    ph8 = m_t % 8;
    s.e    = (ph >= DIV / 2);
    s.q    = (ph >= DIV / 4) && (ph < 3 * DIV / 4);
    s.e8   = (ph8 >= 4);
    s.q8   = (ph8 >= 2) && (ph8 < 6);
    s.nres = (m_pulse == 0);
    s.nirq = m_nirq;
    s.bank = m_bank;
    s.wcnt = 4'(m_cnt);
    exp_q.push_back(s);
  endtask

  task automatic drive_step(input logic r, input logic [15:0] a, input logic [7:0] d,
                            input bit fall);
    rnw = r; addr = a; data = d;
    if (fall) begin
      nvblk = 1'b0; low_cnt = 0;
    end else if (!nvblk) begin
      low_cnt++;
      if (low_cnt >= 6) nvblk = 1'b1;
    end
    model_step();
  endtask

  task automatic tick(input logic r, input logic [15:0] a, input logic [7:0] d, input bit fall);
    @(negedge clk);
    drive_step(r, a, d, fall);
  endtask

  task automatic bus_cycle(input logic r, input logic [15:0] a, input logic [7:0] d,
                           input int fall_off);
    while (m_t % DIV != 0) tick(1'b1, 16'h0000, 8'h00, 1'b0);
    for (int i = 0; i < DIV; i++) tick(r, a, d, i == fall_off);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus_cycle(1'b1, 16'($urandom), 8'($urandom), -1);
  endtask

  // kick_mode: 0 none, 1 kick coincident with vb_start, 2 kick later in the frame.
  task automatic frame(input int kick_mode);
    int slot;
    slot = int'($urandom_range(0, 2));
    if (kick_mode == 1) bus_cycle(1'b0, 16'h8000, 8'($urandom), 1);
    else                bus_cycle(1'b1, 16'($urandom), 8'($urandom), 1);
    for (int b = 0; b < 3; b++) begin
      if (kick_mode == 2 && b == slot) bus_cycle(1'b0, 16'h8000, 8'($urandom), -1);
      else                             bus_cycle(1'b1, 16'($urandom), 8'($urandom), -1);
    end
  endtask

  task automatic apply_reset();
    snap_t act, rst_exp;
    @(negedge clk);
    rst_n = 1'b0; nvblk = 1'b1; rnw = 1'b1; low_cnt = 0;
    #1;
    act = {e, q, e8, q8, nres, nirq, bank, wcnt};
    rst_exp = '{e: 1'b0, q: 1'b0, e8: 1'b0, q8: 1'b0, nres: 1'b0, nirq: 1'b1,
                bank: 2'b00, wcnt: 4'h0};
    check("reset_values", act, rst_exp);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_init();
    drive_step(1'b1, 16'h0000, 8'h00, 1'b0);
  endtask

  // Monitor: compares whatever the DUT presents after each edge.
  initial begin
    snap_t act, exp;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        act = {e, q, e8, q8, nres, nirq, bank, wcnt};
        check("edge", act, exp);
      end
    end
  end

  initial begin
    #1ms;
    n_bad++;
    $display("FAIL timeout @%0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    model_init();
    apply_reset();
    idle(4);

    // VBLANK interrupt, ignored read of IACK, then acknowledge.
    bus_cycle(1'b1, 16'h0000, 8'h00, 1);
    idle(2);
    bus_cycle(1'b1, 16'h8400, 8'h00, -1);
    bus_cycle(1'b0, 16'h8400, 8'h00, -1);
    idle(2);

    // Ten unkicked VBLANKs expire the watchdog; a bank write inside the pulse is ignored.
    bus_cycle(1'b0, 16'h8A00, 8'h01, -1);
    bus_cycle(1'b0, 16'h8000, 8'h00, -1);
    for (int f = 0; f < LIMIT - 1; f++) frame(0);
    bus_cycle(1'b1, 16'h0000, 8'h00, 1);
    bus_cycle(1'b0, 16'h8A00, 8'h03, -1);
    idle(5);

    // Regular kicks keep the CPU running.
    bus_cycle(1'b0, 16'h8000, 8'h00, -1);
    for (int f = 0; f < 50; f++) frame((f % 5 == 4) ? (((f / 5) % 2 == 0) ? 1 : 2) : 0);

    bus_cycle(1'b0, 16'h8A00, 8'h03, -1);
    bus_cycle(1'b1, 16'h8A00, 8'h00, -1);
    bus_cycle(1'b0, 16'h8BFF, 8'hFE, -1);
    idle(1);

    // Randomised bus traffic around the decoded regions.
    for (int f = 0; f < 40; f++) begin
      for (int b = 0; b < 4; b++) begin
        logic [15:0] a;
        case ($urandom_range(0, 4))
          0:       a = 16'h8000 | 16'($urandom_range(0, 1023));
          1:       a = 16'h8400 | 16'($urandom_range(0, 1023));
          2:       a = 16'h8800 | 16'($urandom_range(0, 2047));
          3:       a = 16'h8A00;
          default: a = 16'($urandom);
        endcase
        bus_cycle(1'($urandom_range(0, 1)), a, 8'($urandom),
                  (b == 0) ? int'($urandom_range(0, 3)) : -1);
      end
    end

    // Reset five clocks into a watchdog pulse.
    bus_cycle(1'b0, 16'h8000, 8'h00, -1);
    for (int f = 0; f < LIMIT + 2; f++) begin
      bus_cycle(1'b1, 16'h0000, 8'h00, 1);
      if (m_pulse > 0) break;
      idle(3);
    end
    repeat (5) tick(1'b1, 16'h0000, 8'h00, 1'b0);
    apply_reset();
    idle(6);

    // VBLANK coincident with acknowledge leaves the interrupt asserted.
    bus_cycle(1'b0, 16'h8400, 8'h00, 1);
    idle(3);
    bus_cycle(1'b0, 16'h8400, 8'h00, -1);
    idle(2);

    @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain actual %0d pending required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sys86_cpu_ctrl.md
Name: sys86_cpu_ctrl

Overview:
Parametrised CPU support controller for System86 CPU boards. It is the next-generation companion to the CUS47-class address generator.
- Generates quadrature E/Q CPU clocks from CLK_6M.
- Decodes committed bus writes for watchdog kick, IRQ acknowledge and a tile-bank latch.
- Raises a VBLANK interrupt.
- Drives a timed watchdog reset pulse.
- Fully synchronous to CLK_6M, unlike the original ripple-clocked watchdog.

Parameters:
- CLK_DIV, 4: CLK_6M cycles per E cycle; must be a multiple of 4 and at least 4.
- WDOG_WIDTH, 4: watchdog counter width.
- WDOG_LIMIT, 10: VBLANK starts without a kick before reset; must satisfy 1 ≤ WDOG_LIMIT < 2^WDOG_WIDTH.
- RES_PULSE, 16: CLK_6M cycles nRES is held low after expiry; minimum 1.
- WDOG_ADDR, 16'h8000: watchdog kick write address, decoded on A[15:10].
- IACK_ADDR, 16'h8400: IRQ acknowledge write address, decoded on A[15:10].
- BANK_ADDR, 16'h8800: bank latch write address, decoded on A[15:11].
- BANK_WIDTH, 2: width of the bank register, taken from D[BANK_WIDTH-1:0].

Ports:
- CLK_6M, in, 1: system clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- nVBLK, in, 1: VBLANK, active low, asynchronous to CLK_6M.
- RnW, in, 1: CPU read/not-write.
- A, in, 16: CPU address.
- D, in, 8: CPU write data.
- E, out, 1: CPU E clock.
- Q, out, 1: CPU Q clock; leads E by a quarter cycle.
- nRES, out, 1: CPU reset, active low.
- nIRQ, out, 1: CPU interrupt, active low, level.
- BANK, out, BANK_WIDTH: registered bank select.
- wdog_count, out, WDOG_WIDTH: watchdog count, for debug.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Phase counter = 0; E = 0; Q = 0; nIRQ = 1; BANK = 0; wdog_count = 0.
  - Synchroniser flops = 1; reset-pulse counter = 0.
  - nRES = 0 combinationally while rst_n is low.
  - After release, nRES = 1 unless a watchdog pulse is active.
- Phase counter:
  - ph counts 0..CLK_DIV-1 and wraps.
  - Q (registered) is high for ph in [CLK_DIV/4, 3·CLK_DIV/4).
  - E (registered) is high for ph in [CLK_DIV/2, CLK_DIV).
  - The phase counter keeps running during watchdog reset so the CPU is clocked while held in reset.
- Write commit:
  - commit = (ph == CLK_DIV-1) & ~RnW & ~res_active. This is the last CLK_6M cycle of E high.
  - Decodes are evaluated only on commit, giving exactly one action per bus cycle.
- Bank latch: on commit with A[15:11] == BANK_ADDR[15:11], BANK <= D[BANK_WIDTH-1:0] on the next edge.
- VBLANK detect:
  - nVBLK passes through a 2-flop synchroniser, then a falling-edge detector produces vb_start.
  - Latency from nVBLK falling to nIRQ low is 3 CLK_6M edges.
- IRQ:
  - vb_start sets nIRQ = 0.
  - A commit to IACK_ADDR sets nIRQ = 1.
  - If both occur in the same cycle, the set wins (nIRQ = 0).
- Watchdog:
  - A commit to WDOG_ADDR clears wdog_count to 0.
  - Otherwise vb_start increments wdog_count.
  - A kick in the same cycle as vb_start wins (count = 0).
  - When vb_start occurs with wdog_count == WDOG_LIMIT-1: expiry. Then wdog_count = 0, res_active = 1, pulse counter loads RES_PULSE-1, nRES = 0.
- Reset pulse:
  - While res_active: pulse counter decrements each clock; commits are ignored; vb_start is ignored for the watchdog; nIRQ is forced to 1; BANK is cleared to 0.
  - When the pulse counter reaches 0, res_active clears on the next edge.
  - nRES is therefore low for exactly RES_PULSE cycles.
- rst_n asserted mid-pulse aborts the pulse; all state returns to reset values.
- Counter widths: phase counter is clog2(CLK_DIV); pulse counter is clog2(RES_PULSE+1). No counter saturates; all wrap by construction.

Decomposition:
- Shared package sys86_cpu_pkg holds:
  - the default address constants WDOG_ADDR, IACK_ADDR and BANK_ADDR;
  - a function for the E/Q phase thresholds.
- One sub-module, sys86_eq_gen, contains the phase counter and E/Q registers and outputs ph_last, which is used as the commit strobe.

Test Plan:
1. Release rst_n with CLK_DIV=4 → E sequence 0,0,1,1 and Q sequence 0,1,1,0 repeating from ph=0; nRES rises with rst_n; CLK_DIV=8 also gives a Q lead of 2 clocks.
2. Drop nVBLK → nIRQ goes low 3 edges later; write to 0x8400 → nIRQ goes high after the commit cycle; a read of 0x8400 has no effect.
3. Ten VBLANK starts with no kick (WDOG_LIMIT=10) → on the 10th, nRES is low for exactly 16 cycles, BANK = 0, nIRQ = 1, wdog_count = 0; E/Q keep toggling throughout.
4. Kick 0x8000 every 5 VBLANKs over 50 frames → nRES never goes low; a kick coincident with vb_start gives wdog_count = 0.
5. Write D=0x03 to 0x8A00 → BANK = 2'b11; write to 0x8A00 during a reset pulse → BANK stays 0.
6. Assert rst_n low 5 cycles into a watchdog pulse → immediate reset values; after release nRES = 1, no residual pulse remains, and the IACK-vs-vb_start collision leaves nIRQ = 0.
